// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between the execute stage
// (requester 0) and the branch unit (requester 1).
//
// Pipeline: accept -> issue stage (drives alu_*) -> result stage (rsp_*).
// One request per cycle is accepted.
//
// Responses arrive two cycles after the accept and cannot be stalled.
//
// A requester may lock the ALU with req_lock. It then keeps the grant until it
// makes a request with req_lock low.
//
// Optional build macro ALU_ARB_ROUND_ROBIN_EN:
//   - defined:   OPEN-state conflicts are resolved by a round-robin pointer.
//   - undefined: requester 0 always wins.
//
// Handshake: a request transfers on a cycle where req_valid[n] and
// req_ready[n] are both high.
//   - req_ready is never raised for a requester that is not valid.
//   - A valid requester that is not ready must keep presenting its request;
//     its operands are only sampled on the transfer cycle.
//   - rsp_valid[n] is a single-cycle pulse with no backpressure.
module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               req_valid,
  input  logic [DATA_WIDTH-1:0]    req_srca0,
  input  logic [DATA_WIDTH-1:0]    req_srca1,
  input  logic [DATA_WIDTH-1:0]    req_srcb0,
  input  logic [DATA_WIDTH-1:0]    req_srcb1,
  input  logic [OPCODE_LENGTH-1:0] req_op0,
  input  logic [OPCODE_LENGTH-1:0] req_op1,
  input  logic [1:0]               req_lock,
  output logic [1:0]               req_ready,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  output logic [1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_result,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    ST_OPEN  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   accept;
  logic   gid;

  logic                     iss_valid;
  logic                     iss_id;
  logic [DATA_WIDTH-1:0]    iss_a;
  logic [DATA_WIDTH-1:0]    iss_b;
  logic [OPCODE_LENGTH-1:0] iss_op;

  logic [1:0]               rsp_valid_q;
  logic [DATA_WIDTH-1:0]    rsp_result_q;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // ptr_q = 0 favours requester 0, 1 favours requester 1
  logic ptr_q;

  // Pointer moves only on OPEN-state accepts, away from the requester just served
  always_ff @(posedge clk) begin
    if (!reset)
      ptr_q <= 1'b0;
    else if (state_q == ST_OPEN && accept)
      ptr_q <= ~gid;
  end
`endif

  // Grant selection and lock FSM next-state; no grants while reset is low
  always_comb begin
    req_ready = 2'b00;
    state_d   = state_q;
    if (reset) begin
      case (state_q)
        ST_OPEN: begin
          if (req_valid == 2'b11) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            req_ready = ptr_q ? 2'b10 : 2'b01;
`else
            req_ready = 2'b01;
`endif
          end else begin
            req_ready = req_valid;
          end
        end
        ST_LOCK0: req_ready = {1'b0, req_valid[0]};
        ST_LOCK1: req_ready = {req_valid[1], 1'b0};
        default:  req_ready = 2'b00;
      endcase
    end
    accept = |req_ready;
    gid    = req_ready[1];
    case (state_q)
      ST_OPEN: begin
        if (accept && req_lock[gid])
          state_d = gid ? ST_LOCK1 : ST_LOCK0;
      end
      ST_LOCK0: begin
        if (req_ready[0] && !req_lock[0])
          state_d = ST_OPEN;
      end
      ST_LOCK1: begin
        if (req_ready[1] && !req_lock[1])
          state_d = ST_OPEN;
      end
      default: state_d = ST_OPEN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset)
      state_q <= ST_OPEN;
    else
      state_q <= state_d;
  end

  // Issue stage: captures the accepted request, empties when nothing accepted
  always_ff @(posedge clk) begin
    if (!reset) begin
      iss_valid <= 1'b0;
      iss_id    <= 1'b0;
      iss_a     <= '0;
      iss_b     <= '0;
      iss_op    <= '0;
    end else begin
      iss_valid <= accept;
      if (accept) begin
        iss_id <= gid;
        iss_a  <= gid ? req_srca1 : req_srca0;
        iss_b  <= gid ? req_srcb1 : req_srcb0;
        iss_op <= gid ? req_op1 : req_op0;
      end
    end
  end

  // Result stage: one-cycle response pulse; result holds between responses
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
    end else begin
      rsp_valid_q <= iss_valid ? (iss_id ? 2'b10 : 2'b01) : 2'b00;
      if (iss_valid)
        rsp_result_q <= alu_result;
    end
  end

  assign alu_srca   = iss_valid ? iss_a : '0;
  assign alu_srcb   = iss_valid ? iss_b : '0;
  assign alu_op     = iss_valid ? iss_op : '0;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a reference ALU on alu_result.
// Expectations follow the build: ALU_ARB_ROUND_ROBIN_EN selects round-robin grants.
module tb_alu_share_arbiter;
  localparam int W   = 32;
  localparam int OPW = 4;
  localparam logic [OPW-1:0] OP_AND = 4'b0000;
  localparam logic [OPW-1:0] OP_OR  = 4'b0001;
  localparam logic [OPW-1:0] OP_ADD = 4'b0010;
  localparam logic [OPW-1:0] OP_SUB = 4'b0110;
  localparam logic [1:0] S_OPEN = 2'd0;
  localparam logic [1:0] S_L0   = 2'd1;
  localparam logic [1:0] S_L1   = 2'd2;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [1:0]     valid;
    logic [1:0]     lock;
    logic [W-1:0]   a0, b0, a1, b1;
    logic [OPW-1:0] op0, op1;
    logic [1:0]     exp_ready;
    logic [1:0]     exp_state;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset;
  logic [1:0] req_valid, req_lock, req_ready, rsp_valid, dbg_state;
  logic [W-1:0] req_srca0, req_srca1, req_srcb0, req_srcb1;
  logic [OPW-1:0] req_op0, req_op1, alu_op;
  logic [W-1:0] alu_srca, alu_srcb, alu_result, rsp_result;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(W), .OPCODE_LENGTH(OPW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_srca0(req_srca0), .req_srca1(req_srca1),
    .req_srcb0(req_srcb0), .req_srcb1(req_srcb1),
    .req_op0(req_op0), .req_op1(req_op1), .req_lock(req_lock),
    .req_ready(req_ready), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .alu_op(alu_op), .alu_result(alu_result), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .dbg_state(dbg_state)
  );

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [OPW-1:0] op);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      default: return '0;
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_srca, alu_srcb, alu_op);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  logic [W+1:0] exp_q[$];
  int           due_q[$];
  logic [W-1:0] last_res = '0;
  logic [W+1:0] mon_e;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        mon_e = exp_q.pop_front();
        void'(due_q.pop_front());
        chk("rsp_valid", W'(rsp_valid), W'(mon_e[W+1:W]));
        chk("rsp_result", rsp_result, mon_e[W-1:0]);
        last_res = mon_e[W-1:0];
      end else begin
        chk("rsp_idle", W'(rsp_valid), '0);
        chk("rsp_hold", rsp_result, last_res);
      end
    end
  end

  // ---------------- driver ----------------
  function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] lock,
                              input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [OPW-1:0] op0,
                              input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [OPW-1:0] op1,
                              input logic [1:0] er, input logic [1:0] es);
    vec_t v;
    v.valid = valid; v.lock = lock;
    v.a0 = a0; v.b0 = b0; v.op0 = op0;
    v.a1 = a1; v.b1 = b1; v.op1 = op1;
    v.exp_ready = er; v.exp_state = es;
    return v;
  endfunction

  // Apply one cycle of stimulus, check grant/state, predict the response
  task automatic drive(input vec_t v, input string tag);
    req_valid = v.valid; req_lock = v.lock;
    req_srca0 = v.a0; req_srcb0 = v.b0; req_op0 = v.op0;
    req_srca1 = v.a1; req_srcb1 = v.b1; req_op1 = v.op1;
    #3;
    chk({tag, ":ready"}, W'(req_ready), W'(v.exp_ready));
    chk({tag, ":state"}, W'(dbg_state), W'(v.exp_state));
    if (v.exp_ready[0]) begin
      exp_q.push_back({2'b01, alu_f(v.a0, v.b0, v.op0)});
      due_q.push_back(cyc + 2);
    end
    if (v.exp_ready[1]) begin
      exp_q.push_back({2'b10, alu_f(v.a1, v.b1, v.op1)});
      due_q.push_back(cyc + 2);
    end
    @(posedge clk);
    cyc++;
    if (!reset) begin
      exp_q.delete();
      due_q.delete();
      last_res = '0;
    end
    #1;
  endtask

  vec_t vecs[$];
  vec_t idle;

  initial begin
    idle = mk(2'b00, 2'b00, 0, 0, OP_AND, 0, 0, OP_AND, 2'b00, S_OPEN);

    // Reset: no grants while reset is low, everything cleared after it
    reset = 1'b0;
    req_valid = 2'b11; req_lock = 2'b00;
    req_srca0 = 1; req_srcb0 = 2; req_op0 = OP_ADD;
    req_srca1 = 3; req_srcb1 = 4; req_op1 = OP_ADD;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_ready", W'(req_ready), '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_valid = 2'b00;
    #1;
    chk("rst_alu_srca", alu_srca, '0);
    chk("rst_alu_srcb", alu_srcb, '0);
    chk("rst_alu_op", W'(alu_op), '0);
    chk("rst_state", W'(dbg_state), W'(S_OPEN));
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Single request: 5 + 7
    vecs.push_back(mk(2'b01, 2'b00, 5, 7, OP_ADD, 0, 0, OP_AND, 2'b01, S_OPEN));
    vecs.push_back(idle);
    vecs.push_back(idle);
    // Lone requester 1 is granted; afterwards requester 0 is favoured
    vecs.push_back(mk(2'b10, 2'b00, 0, 0, OP_AND, 100, 23, OP_ADD, 2'b10, S_OPEN));
    // Contention for four cycles
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(2'b11, 2'b00, W'(10 + i), 1, OP_ADD, W'(200 + i), 3, OP_SUB,
                        (RR && (i % 2 == 1)) ? 2'b10 : 2'b01, S_OPEN));
    // Requester 0 drops, requester 1 gets through
    vecs.push_back(mk(2'b10, 2'b00, 0, 0, OP_AND, 32'hAAAA, 32'h0F0F, OP_OR, 2'b10, S_OPEN));
    // Lock by requester 1; requester 0 blocked and its changing operands ignored
    vecs.push_back(mk(2'b10, 2'b10, 0, 0, OP_AND, 9, 4, OP_SUB, 2'b10, S_OPEN));
    vecs.push_back(mk(2'b01, 2'b00, 1, 1, OP_ADD, 0, 0, OP_AND, 2'b00, S_L1));
    vecs.push_back(mk(2'b01, 2'b00, 2, 2, OP_ADD, 0, 0, OP_AND, 2'b00, S_L1));
    vecs.push_back(mk(2'b11, 2'b00, 3, 3, OP_ADD, 50, 8, OP_SUB, 2'b10, S_L1));
    vecs.push_back(mk(2'b01, 2'b00, 40, 2, OP_ADD, 0, 0, OP_AND, 2'b01, S_OPEN));
    // Lock by requester 0; requester 1 blocked even with the ALU idle
    vecs.push_back(mk(2'b01, 2'b01, 6, 6, OP_ADD, 0, 0, OP_AND, 2'b01, S_OPEN));
    vecs.push_back(mk(2'b11, 2'b01, 7, 1, OP_SUB, 9, 9, OP_ADD, 2'b01, S_L0));
    vecs.push_back(mk(2'b10, 2'b00, 0, 0, OP_AND, 9, 9, OP_ADD, 2'b00, S_L0));
    vecs.push_back(mk(2'b11, 2'b00, 32'hF0, 32'h3C, OP_AND, 9, 9, OP_ADD, 2'b01, S_L0));
    vecs.push_back(mk(2'b10, 2'b00, 0, 0, OP_AND, 1, 2, OP_ADD, 2'b10, S_OPEN));
    vecs.push_back(idle);
    vecs.push_back(idle);

    foreach (vecs[i]) drive(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back stream: i - 1 for i = 0..7, one response per cycle
    for (int i = 0; i < 8; i++)
      drive(mk(2'b01, 2'b00, W'(i), 1, OP_SUB, 0, 0, OP_AND, 2'b01, S_OPEN),
            $sformatf("b2b%0d", i));
    drive(idle, "b2b_drain0");
    drive(idle, "b2b_drain1");

    // Reset with both stages full and the FSM in LOCK0
    drive(mk(2'b01, 2'b01, 11, 22, OP_ADD, 0, 0, OP_AND, 2'b01, S_OPEN), "rmid_a");
    drive(mk(2'b01, 2'b01, 33, 44, OP_ADD, 0, 0, OP_AND, 2'b01, S_L0), "rmid_b");
    reset = 1'b0;
    drive(mk(2'b11, 2'b00, 1, 1, OP_ADD, 2, 2, OP_ADD, 2'b00, S_L0), "rmid_rst");
    reset = 1'b1;
    chk("rmid_alu_srca", alu_srca, '0);
    chk("rmid_alu_op", W'(alu_op), '0);
    chk("rmid_state", W'(dbg_state), W'(S_OPEN));
    drive(mk(2'b10, 2'b00, 0, 0, OP_AND, 77, 3, OP_ADD, 2'b10, S_OPEN), "rmid_req1");
    drive(idle, "rmid_drain0");
    drive(idle, "rmid_drain1");
    drive(idle, "rmid_drain2");

    chk("queue_drained", W'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter OPCODE_LENGTH, default 4, ALU operation code width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports req_valid[1:0]  input  2  per-requester request valid (index 0 = execute stage, 1 = branch unit).
REQ-006 SHALL have ports req_srca0/req_srca1, req_srcb0/req_srcb1  input  DATA_WIDTH each  operands per requester.
REQ-007 SHALL have ports req_op0/req_op1  input  OPCODE_LENGTH each  ALU operation per requester.
REQ-008 SHALL have ports req_lock[1:0]  input  2  requester asks to keep the grant after this request.
REQ-009 SHALL have ports req_ready[1:0]  output  2  request accepted this cycle when valid and ready both high.
REQ-010 SHALL have ports alu_srca, alu_srcb  output  DATA_WIDTH; alu_op  output  OPCODE_LENGTH  drive the shared combinational ALU.
REQ-011 SHALL have port alu_result  input  DATA_WIDTH  combinational ALU result for the alu_* drive of the same cycle.
REQ-012 SHALL have ports rsp_valid[1:0]  output  2; rsp_result  output  DATA_WIDTH  one-cycle response pulse and result per requester.

Function
REQ-013 SHALL accept at most one request per cycle; req_ready is one-hot or zero and combinationally depends only on req_valid, FSM state and priority pointer.
REQ-014 SHALL register the accepted operands/op/requester id into an issue stage; alu_srca/alu_srcb/alu_op SHALL come from that stage, driven to all-zero operands and op 4'b0000 when the stage is empty.
REQ-015 SHALL capture alu_result and requester id into a result register at the edge after issue; rsp_valid[id] high for exactly one cycle with rsp_result; latency accept-edge to rsp_valid = 2 cycles; throughput 1 request/cycle; no response backpressure.
REQ-016 SHALL hold rsp_result at its last value when rsp_valid is zero.
REQ-017 SHALL implement FSM states OPEN, LOCK0, LOCK1.
REQ-018 OPEN: arbitrate both requesters per REQ-025; accepting requester n with req_lock[n]=1 -> LOCKn; otherwise stay OPEN.
REQ-019 LOCKn: req_ready only for requester n; other requester blocked even if ALU idle; accepting requester n with req_lock[n]=0 -> OPEN; requester n idle -> stay LOCKn.
REQ-020 Single requester valid in OPEN SHALL be granted the same cycle regardless of pointer.
REQ-021 Priority pointer SHALL update only on an accept in OPEN, to favour the non-granted requester next.
REQ-022 Simultaneous accept and response in same cycle SHALL both occur with no bubble.
REQ-023 Requester changing operands while valid and not ready SHALL have no effect; only accepted values are issued.

Reset
REQ-024 reset low at a rising edge SHALL set FSM OPEN, pointer favour requester 0, issue and result stages empty, rsp_valid=0, rsp_result=0, alu_* = 0, discarding in-flight requests with no response; req_ready=0 while reset is low.

Configuration
REQ-025 Macro ALU_ARB_ROUND_ROBIN_EN: defined -> OPEN-state conflicts resolved by round-robin pointer; undefined -> fixed priority, requester 0 always wins, pointer logic absent; lock behaviour identical in both builds.

Verification
REQ-026 Single request: req_valid=01, srca=5, srcb=7, op=4'b0010 -> req_ready=01 same cycle, rsp_valid=01 with rsp_result=12 two cycles later.
REQ-027 Contention, RR build: both valid 4 cycles -> grants 0,1,0,1; responses alternate with 2-cycle latency; fixed build -> grants 0,0,0,0, requester 1 granted only when requester 0 drops valid.
REQ-028 Lock: requester 1 accepted with lock=1, then 2 idle cycles, then lock=0 request -> requester 0 valid throughout gets req_ready=0 until the cycle after the unlock accept, FSM returns OPEN.
REQ-029 Back-to-back: requester 0 streams 8 requests (op SUB, srca=i, srcb=1) -> 8 consecutive rsp_valid pulses, results 0xFFFFFFFF,0..6, no bubbles.
REQ-030 Reset mid-operation: assert reset with issue and result stages full and FSM LOCK0 -> next cycle rsp_valid=0, no response for dropped requests, FSM OPEN, requester 1 request granted first cycle after reset release.
